// File: rtl/sprite_plotter.sv
// Sprite plotter: scans a (2^WB)x(2^HB) sprite from a 1-cycle-latency object memory and
// issues one VGA write per visible pixel, with erase mode, transparency skip and clipping.
module sprite_plotter #(
   parameter int unsigned XW        = 8,
   parameter int unsigned YW        = 7,
   parameter int unsigned WB        = 3,
   parameter int unsigned HB        = 3,
   parameter int unsigned CW        = 3,
   parameter int unsigned SCREEN_W  = 160,
   parameter int unsigned SCREEN_H  = 120,
   parameter bit          TRANSP_EN = 1'b1,
   parameter logic [CW-1:0] TRANSP_C = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             erase_i,
   input  logic [XW-1:0]    x_i,
   input  logic [YW-1:0]    y_i,
   input  logic [CW-1:0]    bg_colour_i,
   output logic [WB+HB-1:0] mem_addr_o,
   input  logic [CW-1:0]    mem_data_i,
   output logic [XW-1:0]    vga_x_o,
   output logic [YW-1:0]    vga_y_o,
   output logic [CW-1:0]    vga_colour_o,
   output logic             plot_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [XW:0] ScrW = (XW+1)'(SCREEN_W);
   localparam logic [YW:0] ScrH = (YW+1)'(SCREEN_H);

   typedef enum logic [1:0] {StIdle, StDraw, StFlush, StDone} state_e;

   state_e          state_q;
   logic [WB-1:0]   xc_q, xc_pipe_q;
   logic [HB-1:0]   yc_q, yc_pipe_q;
   logic            valid_q;
   logic [XW-1:0]   x_q;
   logic [YW-1:0]   y_q;
   logic            erase_q;
   logic [CW-1:0]   bg_q;
   logic            busy_q, done_q;
   logic [XW-1:0]   last_x_q;
   logic [YW-1:0]   last_y_q;
   logic [CW-1:0]   last_c_q;

   logic [XW:0]     sum_x;
   logic [YW:0]     sum_y;
   logic [CW-1:0]   pix_colour;
   logic            clip, transp, plot;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         xc_q      <= '0;
         yc_q      <= '0;
         xc_pipe_q <= '0;
         yc_pipe_q <= '0;
         valid_q   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         erase_q   <= 1'b0;
         bg_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // Pipeline stage so the coordinates line up with mem_data one cycle later.
         xc_pipe_q <= xc_q;
         yc_pipe_q <= yc_q;
         valid_q   <= (state_q == StDraw);
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  x_q     <= x_i;
                  y_q     <= y_i;
                  erase_q <= erase_i;
                  bg_q    <= bg_colour_i;
                  xc_q    <= '0;
                  yc_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StDraw;
               end
            end
            StDraw: begin
               xc_q <= xc_q + 1'b1;
               if (&xc_q) yc_q <= yc_q + 1'b1;
               if ((&xc_q) && (&yc_q)) state_q <= StFlush;
            end
            StFlush: begin
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      sum_x      = {1'b0, x_q} + (XW+1)'(xc_pipe_q);
      sum_y      = {1'b0, y_q} + (YW+1)'(yc_pipe_q);
      clip       = (sum_x >= ScrW) || (sum_y >= ScrH);
      transp     = TRANSP_EN && !erase_q && (mem_data_i == TRANSP_C);
      plot       = valid_q && !clip && !transp;
      pix_colour = erase_q ? bg_q : mem_data_i;
   end

   // Keep the last written pixel on the adapter bus while nothing is plotted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_x_q <= '0;
         last_y_q <= '0;
         last_c_q <= '0;
      end else if (plot) begin
         last_x_q <= sum_x[XW-1:0];
         last_y_q <= sum_y[YW-1:0];
         last_c_q <= pix_colour;
      end
   end

   always_comb begin
      mem_addr_o   = {yc_q, xc_q};
      plot_o       = plot;
      vga_x_o      = plot ? sum_x[XW-1:0] : last_x_q;
      vga_y_o      = plot ? sum_y[YW-1:0] : last_y_q;
      vga_colour_o = plot ? pix_colour : last_c_q;
      busy_o       = busy_q;
      done_o       = done_q;
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: a reference model pushes expected pixels into a queue
// at start, and a negedge monitor pops and compares every plot the DUT issues.
module tb_sprite_plotter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pixel_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, erase;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] bg;
   logic [5:0] mem_addr;
   logic [2:0] mem_data;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_c;
   logic       plot, busy, done;

   logic [2:0] mem [64];
   pixel_t     exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         plots_seen = 0;

   sprite_plotter dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .erase_i      (erase),
      .x_i          (x_in),
      .y_i          (y_in),
      .bg_colour_i  (bg),
      .mem_addr_o   (mem_addr),
      .mem_data_i   (mem_data),
      .vga_x_o      (vga_x),
      .vga_y_o      (vga_y),
      .vga_colour_o (vga_c),
      .plot_o       (plot),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) mem_data <= mem[mem_addr];

   always @(negedge clk) begin
      if (plot) begin
         pixel_t got, e;
         got = '{x: vga_x, y: vga_y, c: vga_c};
         plots_seen++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, expected no plot",
                   vga_x, vga_y, vga_c);
         end else begin
            e = exp_q.pop_front();
            assert (got === e) else begin
               fails++;
               $error("FAIL plot_pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                      got.x, got.y, got.c, e.x, e.y, e.c);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: full-width sums, clip, then transparency (draw mode only).
   task automatic push_expected(input logic [7:0] x, input logic [6:0] y, input logic er,
                                input logic [2:0] bgc);
      for (int a = 0; a < 64; a++) begin
         int sx, sy;
         logic [2:0] c;
         sx = int'(x) + (a % 8);
         sy = int'(y) + (a / 8);
         c  = er ? bgc : mem[a];
         if (sx < 160 && sy < 120 && !(!er && mem[a] == 3'b000))
            exp_q.push_back('{x: sx[7:0], y: sy[6:0], c: c});
      end
   endtask

   task automatic run_draw(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic er, input logic [2:0] bgc, input int exp_plots,
                           input int pulse_at);
      int n;
      bit seen;
      push_expected(x, y, er, bgc);
      plots_seen = 0;
      @(negedge clk);
      start = 1'b1; x_in = x; y_in = y; erase = er; bg = bgc;
      @(posedge clk);
      #1;
      start = 1'b0; x_in = ~x; y_in = ~y; erase = ~er; bg = ~bgc;
      check({tag, "_busy_start"}, busy, 1);
      n = 0;
      seen = 0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         start = (pulse_at != 0 && n == pulse_at);
         if (pulse_at != 0 && n == pulse_at + 2) check({tag, "_busy_ignored"}, busy, 1);
         if (done) seen = 1;
      end
      start = 1'b0;
      check({tag, "_done_edge"}, n, 65);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_plot_count"}, plots_seen, exp_plots);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; erase = 1'b0; x_in = '0; y_in = '0; bg = '0;
      for (int a = 0; a < 64; a++) mem[a] = 3'b000;
      #3;
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_vga", {vga_x, vga_y, vga_c}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Colour = addr[2:0]: the XC=0 column is transparent, leaving 56 plots.
      for (int a = 0; a < 64; a++) mem[a] = a[2:0];
      run_draw("draw", 8'd10, 7'd20, 1'b0, 3'b000, 56, 0);
      check("hold_x", vga_x, 17);
      check("hold_y", vga_y, 27);
      check("hold_c", vga_c, 7);

      for (int a = 0; a < 64; a++) mem[a] = (a == 9) ? 3'b101 : 3'b000;
      run_draw("transp", 8'd30, 7'd40, 1'b0, 3'b000, 1, 0);
      check("transp_x", vga_x, 31);
      check("transp_y", vga_y, 41);
      check("transp_c", vga_c, 5);

      for (int a = 0; a < 64; a++) mem[a] = 3'b000;
      run_draw("erase", 8'd50, 7'd40, 1'b1, 3'b000, 64, 0);

      for (int a = 0; a < 64; a++) mem[a] = 3'b111;
      run_draw("clip", 8'd156, 7'd116, 1'b0, 3'b000, 16, 0);
      check("clip_last_x", vga_x, 159);
      check("clip_last_y", vga_y, 119);

      for (int a = 0; a < 64; a++) mem[a] = 3'b011;
      run_draw("restart_ignored", 8'd0, 7'd0, 1'b0, 3'b000, 64, 9);

      // Abort mid-draw with reset, then a fresh draw must restart at pixel 0.
      push_expected(8'd20, 7'd10, 1'b0, 3'b000);
      plots_seen = 0;
      @(negedge clk);
      start = 1'b1; x_in = 8'd20; y_in = 7'd10; erase = 1'b0; bg = 3'b000;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #3;
      check("pre_abort_plot", plot, 1);
      rst_n = 1'b0;
      #1;
      check("abort_plot", plot, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_plots_seen", plots_seen, 28);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_draw("after_abort", 8'd20, 7'd10, 1'b0, 3'b000, 64, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
